fruit_spawner: RTL



---
 rtl/fruit_spawner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fruit_spawner.sv
// fruit_spawner: spawns a row of seven fruit lanes and drops it one row
// per FALL_TICKS enabled cycles, respawning after a catch or a miss.
`timescale 1ns/1ps
module fruit_spawner #(
  parameter logic [6:0]  Y_TOP        = 7'd0,
  parameter logic [6:0]  Y_BOTTOM     = 7'd119,
  parameter logic [25:0] FALL_TICKS   = 26'd2_500_000,
  parameter logic [25:0] GAP_TICKS    = 26'd25_000_000,
  parameter logic [6:0]  LANE_SPACING = 7'd18,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       hit,
  output logic [6:0] fruitx,
  output logic [6:0] fruitx2,
  output logic [6:0] fruitx3,
  output logic [6:0] fruitx4,
  output logic [6:0] fruitx5,
  output logic [6:0] fruitx6,
  output logic [6:0] fruitx7,
  output logic [6:0] fruity,
  output logic [2:0] colour,
  output logic       catch,
  output logic       miss,
  output logic       active
);

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    FALL,
    GAP
  } state_t;

  localparam logic [2:0] NO_FRUIT = 3'b111;

  state_t            state_q, state_d;
  logic [25:0]       cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [6:0][6:0]   lane_q, lane_d;
  logic [6:0]        y_q, y_d;
  logic [2:0]        col_q, col_d;
  logic              catch_q, catch_d;
  logic              miss_q, miss_d;
  logic              act_q, act_d;
  logic              fb;
  logic [2:0]        col_raw;

  assign fb      = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];
  assign col_raw = lfsr_q[9:7];

  // State register; everything freezes while enable is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      lane_q  <= '0;
      y_q     <= Y_TOP;
      col_q   <= NO_FRUIT;
      catch_q <= 1'b0;
      miss_q  <= 1'b0;
      act_q   <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      lane_q  <= lane_d;
      y_q     <= y_d;
      col_q   <= col_d;
      catch_q <= catch_d;
      miss_q  <= miss_d;
      act_q   <= act_d;
    end
  end

  // Next-state and next-output logic; hit only matters while falling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = {lfsr_q[14:0], fb};
    lane_d  = lane_q;
    y_d     = y_q;
    col_d   = col_q;
    catch_d = 1'b0;
    miss_d  = 1'b0;
    act_d   = act_q;
    unique case (state_q)
      IDLE: begin
        state_d = SPAWN;
      end
      SPAWN: begin
        for (int i = 0; i < 7; i++) begin
          lane_d[i] = lfsr_q[6:0]
                    + 7'(i) * LANE_SPACING;
        end
        col_d   = (col_raw == NO_FRUIT)
                ? 3'b000 : col_raw;
        y_d     = Y_TOP;
        cnt_d   = '0;
        act_d   = 1'b1;
        state_d = FALL;
      end
      FALL: begin
        if (hit) begin
          catch_d = 1'b1;
          col_d   = NO_FRUIT;
          act_d   = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == FALL_TICKS - 26'd1) begin
          cnt_d = '0;
          if (y_q == Y_BOTTOM) begin
            miss_d  = 1'b1;
            col_d   = NO_FRUIT;
            act_d   = 1'b0;
            state_d = GAP;
          end else begin
            y_d = y_q + 7'd1;
          end
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_TICKS - 26'd1) begin
          cnt_d   = '0;
          state_d = SPAWN;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
    endcase
  end

  assign fruitx  = lane_q[0];
  assign fruitx2 = lane_q[1];
  assign fruitx3 = lane_q[2];
  assign fruitx4 = lane_q[3];
  assign fruitx5 = lane_q[4];
  assign fruitx6 = lane_q[5];
  assign fruitx7 = lane_q[6];
  assign fruity  = y_q;
  assign colour  = col_q;
  assign catch   = catch_q;
  assign miss    = miss_q;
  assign active  = act_q;

endmodule
